// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Purpose  : Shared constants for the machine-level interrupt controller:
//            config register offsets, interrupt-id width, mcause interrupt
//            bit position and the request FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

  // Byte offsets within the config window (bits [3:2] select the register)
  localparam logic [3:0] IRQ_ENABLE  = 4'h0;
  localparam logic [3:0] IRQ_PENDING = 4'h4;
  localparam logic [3:0] IRQ_EDGE    = 4'h8;
  localparam logic [3:0] IRQ_CTRL    = 4'hC;

  // Interrupt flag position in mcause
  localparam int MCAUSE_INT_BIT = 31;

  // Wide enough for up to 16 sources
  localparam int IRQ_ID_W = 4;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_REQ    = 2'd1,
    IRQ_ACTIVE = 2'd2
  } irq_state_e;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_enc
// Purpose  : Combinational fixed-priority encoder; the lowest set index wins.
// Ports    : req   - request vector (N_IRQ bits)
//            valid - at least one request bit set
//            id    - index of the winning request (0 when none)
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0]    req,
  output logic                valid,
  output logic [IRQ_ID_W-1:0] id
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = IRQ_ID_W'(i);
      end
    end
  end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Purpose  : Machine-level interrupt controller for the single-cycle RV32
//            core. Latches peripheral requests, applies enable / edge-level
//            mode / fixed priority, and raises one trap request at a time.
//            Blocks further traps from acceptance until mret.
// Ports    : clk        - system clock
//            reset      - asynchronous reset, active low
//            irqIn      - raw requests, synchronous to clk
//            cfgWe/cfgAddr/cfgWdata/cfgRdata - config register window
//            trapReq    - request PC redirect to the trap vector
//            trapTaken  - core redirected PC this cycle
//            mretIn     - core executed mret this cycle
//            mcauseDi   - mcause value; mcauseWe / mepcWe - CSR strobes
//            inHandler  - trap accepted, mret not yet seen
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ      = 8,
  parameter int CAUSE_BASE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irqIn,
  input  logic             cfgWe,
  input  logic [3:0]       cfgAddr,
  input  logic [31:0]      cfgWdata,
  output logic [31:0]      cfgRdata,
  output logic             trapReq,
  input  logic             trapTaken,
  input  logic             mretIn,
  output logic [31:0]      mcauseDi,
  output logic             mcauseWe,
  output logic             mepcWe,
  output logic             inHandler
);

  irq_state_e          state_q;
  irq_state_e          state_d;
  logic [N_IRQ-1:0]    enable_q;
  logic [N_IRQ-1:0]    edge_q;
  logic [N_IRQ-1:0]    pending_q;
  logic [N_IRQ-1:0]    pending_d;
  logic [N_IRQ-1:0]    irq_prev_q;
  logic                gie_q;
  logic [IRQ_ID_W-1:0] id_q;

  logic [N_IRQ-1:0]    rise;
  logic [N_IRQ-1:0]    active;
  logic [N_IRQ-1:0]    w1c_mask;
  logic [N_IRQ-1:0]    auto_clr;
  logic                win_valid;
  logic [IRQ_ID_W-1:0] win_id;
  logic                load_id;
  logic                taking;

  logic [3:0]          reg_sel;
  logic                wr_enable;
  logic                wr_pending;
  logic                wr_edge;
  logic                wr_ctrl;

  // Byte-lane bits of the address and write-data bits above the source
  // count carry no meaning in this window.
  logic unused_cfg;
  assign unused_cfg = ^{cfgAddr[1:0], cfgWdata[31:N_IRQ]};

  assign reg_sel    = {cfgAddr[3:2], 2'b00};
  assign wr_enable  = cfgWe && (reg_sel == IRQ_ENABLE);
  assign wr_pending = cfgWe && (reg_sel == IRQ_PENDING);
  assign wr_edge    = cfgWe && (reg_sel == IRQ_EDGE);
  assign wr_ctrl    = cfgWe && (reg_sel == IRQ_CTRL);

  assign rise   = irqIn & ~irq_prev_q;
  assign active = pending_q & enable_q;

  irq_prio_enc #(
    .N_IRQ (N_IRQ)
  ) u_prio_enc (
    .req   (active),
    .valid (win_valid),
    .id    (win_id)
  );

  // Edge bits: a new rise beats both the W1C write and the acceptance
  // auto-clear in the same cycle. Level bits simply follow irqIn.
  always_comb begin
    w1c_mask = wr_pending ? cfgWdata[N_IRQ-1:0] : '0;
    auto_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      auto_clr[i] = taking && (id_q == IRQ_ID_W'(i));
    end
    pending_d = (edge_q & (rise | (pending_q & ~w1c_mask & ~auto_clr)))
              | (~edge_q & irqIn);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q   <= '0;
      edge_q     <= '0;
      gie_q      <= 1'b0;
      pending_q  <= '0;
      irq_prev_q <= '0;
      id_q       <= '0;
    end else begin
      irq_prev_q <= irqIn;
      pending_q  <= pending_d;
      if (wr_enable) enable_q <= cfgWdata[N_IRQ-1:0];
      if (wr_edge)   edge_q   <= cfgWdata[N_IRQ-1:0];
      if (wr_ctrl)   gie_q    <= cfgWdata[0];
      if (load_id)   id_q     <= win_id;
    end
  end

  // Request FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IRQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request FSM: next state and outputs. The strobes are combinational so
  // the core can write mcause/mepc in the very cycle it redirects the PC.
  always_comb begin
    state_d   = state_q;
    load_id   = 1'b0;
    taking    = 1'b0;
    trapReq   = 1'b0;
    mcauseWe  = 1'b0;
    mepcWe    = 1'b0;
    inHandler = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (gie_q && win_valid) begin
          load_id = 1'b1;
          state_d = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        trapReq = 1'b1;
        // Acceptance takes precedence over a GIE withdrawal
        if (trapTaken) begin
          taking   = 1'b1;
          mcauseWe = 1'b1;
          mepcWe   = 1'b1;
          state_d  = IRQ_ACTIVE;
        end else if (!gie_q) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_ACTIVE: begin
        inHandler = 1'b1;
        if (mretIn) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  // Driven from the latched id only, so it cannot move while in REQ
  assign mcauseDi = (32'(CAUSE_BASE) + 32'(id_q)) | (32'd1 << MCAUSE_INT_BIT);

  always_comb begin
    cfgRdata = '0;
    case (reg_sel)
      IRQ_ENABLE:  cfgRdata[N_IRQ-1:0] = enable_q;
      IRQ_PENDING: cfgRdata[N_IRQ-1:0] = pending_q;
      IRQ_EDGE:    cfgRdata[N_IRQ-1:0] = edge_q;
      IRQ_CTRL:    cfgRdata[1:0]       = {inHandler, gie_q};
      default:     cfgRdata            = '0;
    endcase
  end

endmodule : irq_controller
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Purpose  : Self-checking bench for irq_controller. Expected mcause values
//            are queued when an interrupt is stimulated and popped when the
//            controller raises trapReq; other checks are inline per scenario.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  localparam int N_IRQ      = 8;
  localparam int CAUSE_BASE = 16;

  logic             clk       = 1'b0;
  logic             reset     = 1'b0;
  logic [N_IRQ-1:0] irqIn     = '0;
  logic             cfgWe     = 1'b0;
  logic [3:0]       cfgAddr   = 4'h0;
  logic [31:0]      cfgWdata  = 32'h0;
  logic             trapTaken = 1'b0;
  logic             mretIn    = 1'b0;
  logic [31:0]      cfgRdata;
  logic             trapReq;
  logic [31:0]      mcauseDi;
  logic             mcauseWe;
  logic             mepcWe;
  logic             inHandler;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  irq_controller #(
    .N_IRQ      (N_IRQ),
    .CAUSE_BASE (CAUSE_BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irqIn     (irqIn),
    .cfgWe     (cfgWe),
    .cfgAddr   (cfgAddr),
    .cfgWdata  (cfgWdata),
    .cfgRdata  (cfgRdata),
    .trapReq   (trapReq),
    .trapTaken (trapTaken),
    .mretIn    (mretIn),
    .mcauseDi  (mcauseDi),
    .mcauseWe  (mcauseWe),
    .mepcWe    (mepcWe),
    .inHandler (inHandler)
  );

  always #5 clk = ~clk;

  // Register write lands on the posedge between the two negedges
  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cfgWe = 1'b1; cfgAddr = a; cfgWdata = d;
    @(negedge clk);
    cfgWe = 1'b0; cfgWdata = 32'h0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    cfgAddr = a;
    #1;
    d = cfgRdata;
  endtask

  // Bounded wait for trapReq, sampled on negedges
  task automatic wait_trap(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (trapReq === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [3:0]  addrs [4];
    addrs[0] = 4'h0; addrs[1] = 4'h4; addrs[2] = 4'h8; addrs[3] = 4'hC;
    reset = 1'b0;
    irqIn = 8'hFF;
    repeat (3) @(negedge clk);
    n_cmp++; if (trapReq !== 1'b0) begin n_err++; $display("FAIL reset_trapReq: got %b expected 0", trapReq); end
    n_cmp++; if (inHandler !== 1'b0) begin n_err++; $display("FAIL reset_inHandler: got %b expected 0", inHandler); end
    n_cmp++; if ({mcauseWe, mepcWe} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b expected 00", {mcauseWe, mepcWe}); end
    n_cmp++; if (mcauseDi !== 32'h8000_0010) begin n_err++; $display("FAIL reset_mcause: got %h expected 80000010", mcauseDi); end
    for (int i = 0; i < 4; i++) begin
      cfg_read(addrs[i], rd);
      n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_rdata@%h: got %h expected 00000000", addrs[i], rd); end
    end
    irqIn = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_edge_trap();
    logic [31:0] rd;
    logic [31:0] exp;
    cfg_write(4'h8, 32'h08);
    cfg_write(4'h0, 32'h08);
    cfg_write(4'hC, 32'h01);
    irqIn = 8'h08;                       // rise seen in cycle n
    exp_q.push_back(32'h8000_0013);
    @(negedge clk);
    irqIn = 8'h00;
    n_cmp++; if (trapReq !== 1'b0) begin n_err++; $display("FAIL edge_lat_n1: got %b expected 0", trapReq); end
    @(negedge clk);
    n_cmp++; if (trapReq !== 1'b1) begin n_err++; $display("FAIL edge_lat_n2: got %b expected 1", trapReq); end
    exp = exp_q.pop_front();
    n_cmp++; if (mcauseDi !== exp) begin n_err++; $display("FAIL edge_cause: got %h expected %h", mcauseDi, exp); end
    n_cmp++; if (mcauseWe !== 1'b0) begin n_err++; $display("FAIL edge_we_before_take: got %b expected 0", mcauseWe); end
    trapTaken = 1'b1;
    #1;
    n_cmp++; if ({mcauseWe, mepcWe} !== 2'b11) begin n_err++; $display("FAIL edge_strobes: got %b expected 11", {mcauseWe, mepcWe}); end
    @(negedge clk);
    trapTaken = 1'b0;
    n_cmp++; if ({inHandler, trapReq} !== 2'b10) begin n_err++; $display("FAIL edge_active: got %b expected 10", {inHandler, trapReq}); end
    cfg_read(4'h4, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL edge_autoclear: got %h expected 00000000", rd); end
    cfg_read(4'hC, rd);
    n_cmp++; if (rd !== 32'h3) begin n_err++; $display("FAIL edge_ctrl: got %h expected 00000003", rd); end
    mretIn = 1'b1;
    @(negedge clk);
    mretIn = 1'b0;
    n_cmp++; if ({inHandler, trapReq} !== 2'b00) begin n_err++; $display("FAIL edge_mret: got %b expected 00", {inHandler, trapReq}); end
  endtask

  task automatic test_priority();
    bit          ok;
    int          hi;
    logic [31:0] exp;
    cfg_write(4'h8, 32'h00);
    cfg_write(4'h0, 32'h24);
    irqIn = 8'h24;
    exp_q.push_back(32'h8000_0012);
    wait_trap(ok);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || mcauseDi !== exp) begin n_err++; $display("FAIL prio_cause: got %h (req %b) expected %h", mcauseDi, ok, exp); end
    trapTaken = 1'b1;
    #1;
    n_cmp++; if (mepcWe !== 1'b1) begin n_err++; $display("FAIL prio_mepcWe: got %b expected 1", mepcWe); end
    @(negedge clk);
    trapTaken = 1'b0;
    cfg_write(4'h0, 32'h25);
    irqIn = 8'h25;
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (trapReq !== 1'b0) hi++;
    end
    n_cmp++; if (hi != 0 || inHandler !== 1'b1) begin n_err++; $display("FAIL prio_no_nest: got %0d req cycles inHandler=%b expected 0 / 1", hi, inHandler); end
    mretIn = 1'b1;
    exp_q.push_back(32'h8000_0010);
    @(negedge clk);
    mretIn = 1'b0;
    wait_trap(ok);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || mcauseDi !== exp) begin n_err++; $display("FAIL prio_after_mret: got %h (req %b) expected %h", mcauseDi, ok, exp); end
    trapTaken = 1'b1;
    @(negedge clk);
    trapTaken = 1'b0;
    irqIn = 8'h00;
    @(negedge clk);
    mretIn = 1'b1;
    @(negedge clk);
    mretIn = 1'b0;
    @(negedge clk);
    n_cmp++; if ({trapReq, inHandler} !== 2'b00) begin n_err++; $display("FAIL prio_idle: got %b expected 00", {trapReq, inHandler}); end
  endtask

  task automatic test_gie_withdraw();
    bit          ok;
    logic [31:0] rd;
    logic [31:0] exp;
    cfg_write(4'h0, 32'h01);
    irqIn = 8'h01;
    exp_q.push_back(32'h8000_0010);
    wait_trap(ok);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || mcauseDi !== exp) begin n_err++; $display("FAIL gie_cause: got %h (req %b) expected %h", mcauseDi, ok, exp); end
    cfg_write(4'hC, 32'h00);             // GIE clears at this write's edge
    @(negedge clk);                      // REQ withdraws at the following edge
    n_cmp++; if ({trapReq, mcauseWe} !== 2'b00) begin n_err++; $display("FAIL gie_withdraw: got %b expected 00", {trapReq, mcauseWe}); end
    cfg_read(4'hC, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL gie_ctrl_read: got %h expected 00000000", rd); end
    cfg_write(4'hC, 32'h01);
    exp_q.push_back(32'h8000_0010);
    wait_trap(ok);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || mcauseDi !== exp) begin n_err++; $display("FAIL gie_rearm_cause: got %h (req %b) expected %h", mcauseDi, ok, exp); end
    cfgWe = 1'b1; cfgAddr = 4'hC; cfgWdata = 32'h0;
    trapTaken = 1'b1;
    #1;
    n_cmp++; if ({mcauseWe, mepcWe} !== 2'b11) begin n_err++; $display("FAIL gie_precedence_strobes: got %b expected 11", {mcauseWe, mepcWe}); end
    @(negedge clk);
    cfgWe = 1'b0;
    trapTaken = 1'b0;
    n_cmp++; if ({inHandler, trapReq} !== 2'b10) begin n_err++; $display("FAIL gie_precedence_active: got %b expected 10", {inHandler, trapReq}); end
    cfg_read(4'hC, rd);
    n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL gie_ctrl_handler: got %h expected 00000002", rd); end
    mretIn = 1'b1;
    @(negedge clk);
    mretIn = 1'b0;
    irqIn = 8'h00;
    @(negedge clk);
    n_cmp++; if ({inHandler, trapReq} !== 2'b00) begin n_err++; $display("FAIL gie_after_mret: got %b expected 00", {inHandler, trapReq}); end
  endtask

  task automatic test_w1c();
    logic [31:0] rd;
    cfg_write(4'h0, 32'h00);
    cfg_write(4'h8, 32'h02);
    cfg_read(4'h8, rd);
    n_cmp++; if (rd !== 32'h02) begin n_err++; $display("FAIL w1c_edge_read: got %h expected 00000002", rd); end
    irqIn = 8'h02;
    @(negedge clk);
    irqIn = 8'h00;
    cfg_read(4'h4, rd);
    n_cmp++; if (rd !== 32'h02) begin n_err++; $display("FAIL w1c_set: got %h expected 00000002", rd); end
    cfg_write(4'h4, 32'h02);
    cfg_read(4'h4, rd);
    n_cmp++; if (rd !== 32'h00) begin n_err++; $display("FAIL w1c_clear: got %h expected 00000000", rd); end
    @(negedge clk);
    irqIn = 8'h02;
    cfgWe = 1'b1; cfgAddr = 4'h4; cfgWdata = 32'h02;
    @(negedge clk);
    cfgWe = 1'b0; cfgWdata = 32'h0;
    irqIn = 8'h00;
    cfg_read(4'h4, rd);
    n_cmp++; if (rd !== 32'h02) begin n_err++; $display("FAIL w1c_set_wins: got %h expected 00000002", rd); end
    cfg_write(4'h8, 32'h00);
    irqIn = 8'h10;
    @(negedge clk);
    cfg_write(4'h4, 32'h10);
    cfg_read(4'h4, rd);
    n_cmp++; if (rd !== 32'h10) begin n_err++; $display("FAIL w1c_level_ignored: got %h expected 00000010", rd); end
    irqIn = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_ignored();
    @(negedge clk);
    trapTaken = 1'b1;
    mretIn    = 1'b1;
    #1;
    n_cmp++; if ({mcauseWe, mepcWe} !== 2'b00) begin n_err++; $display("FAIL ignored_strobes: got %b expected 00", {mcauseWe, mepcWe}); end
    @(negedge clk);
    trapTaken = 1'b0;
    mretIn    = 1'b0;
    n_cmp++; if ({inHandler, trapReq} !== 2'b00) begin n_err++; $display("FAIL ignored_state: got %b expected 00", {inHandler, trapReq}); end
  endtask

  task automatic test_async_reset();
    bit          ok;
    logic [31:0] rd;
    logic [31:0] exp;
    cfg_write(4'h0, 32'h01);
    cfg_write(4'hC, 32'h01);
    irqIn = 8'h01;
    exp_q.push_back(32'h8000_0010);
    wait_trap(ok);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || mcauseDi !== exp) begin n_err++; $display("FAIL async_cause: got %h (req %b) expected %h", mcauseDi, ok, exp); end
    #2;
    reset = 1'b0;                        // between edges, no clock edge follows yet
    #1;
    n_cmp++; if (trapReq !== 1'b0) begin n_err++; $display("FAIL async_trapReq: got %b expected 0", trapReq); end
    cfg_read(4'h0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL async_enable: got %h expected 00000000", rd); end
    irqIn = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_edge_trap();
    test_priority();
    test_gie_withdraw();
    test_w1c();
    test_ignored();
    test_async_reset();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_irq_controller
`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Machine-level interrupt controller for the single-cycle RV32 core.
- Latches up to N_IRQ peripheral requests, applies enable, mode and priority, and presents one trap request at a time. On acceptance it supplies the mcause value and CSR write strobes, and it blocks further traps until mret.
- Configured through a memory-mapped register window on the core's data bus.

Parameters:
N_IRQ, 8, number of interrupt sources (1..16)
CAUSE_BASE, 16, mcause exception code for source 0; source i reports CAUSE_BASE+i

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset (asserted when 0)
irqIn  input  N_IRQ  raw requests, synchronous to clk
cfgWe  input  1  config register write strobe
cfgAddr  input  4  byte address within window; bits [3:2] select register
cfgWdata  input  32  config write data
cfgRdata  output  32  config read data, combinational from cfgAddr
trapReq  output  1  request core to redirect PC to trap vector
trapTaken  input  1  one-cycle pulse: core redirected PC this cycle
mretIn  input  1  one-cycle pulse: core executed mret
mcauseDi  output  32  cause value for mcause CSR
mcauseWe  output  1  mcause write strobe
mepcWe  output  1  mepc write strobe
inHandler  output  1  trap accepted, mret not yet seen

Behaviour:
- Register map:
  - 0x0 ENABLE (rw, N_IRQ bits).
  - 0x4 PENDING (read; write-1-to-clear for edge-mode bits only).
  - 0x8 EDGE (rw; 1=rising-edge, 0=level).
  - 0xC CTRL: bit0 GIE (rw), bit1 inHandler (ro).
  - Unused bits read 0.
- Reset: ENABLE=0, EDGE=0, GIE=0, PENDING=0, irqPrev=0, FSM=IDLE, latched id=0.
  - Outputs at reset: trapReq=0, mcauseWe=0, mepcWe=0, inHandler=0, mcauseDi=32'h8000_0000|CAUSE_BASE.
- irqPrev register samples irqIn every cycle; rise = irqIn & ~irqPrev.
- Edge-mode pending bits:
  - set on rise;
  - cleared by a W1C write;
  - same-cycle set and clear: set wins.
- Level-mode pending bits: PENDING[i] <= irqIn[i] every cycle; W1C has no effect.
- Active = PENDING & ENABLE. Winner = lowest active index (fixed priority).
- FSM states IDLE, REQ, ACTIVE:
  - IDLE: if GIE && |Active, latch winner id and go to REQ.
  - REQ: trapReq=1; mcauseDi={1'b1, 31'(CAUSE_BASE+id)}, stable while in REQ.
    - If trapTaken: mcauseWe=mepcWe=1 combinationally in the same cycle; go to ACTIVE. Edge-mode bit id is auto-cleared at that edge.
    - Else if GIE==0: withdraw to IDLE. trapTaken takes precedence over withdrawal.
    - The latched id does not change in REQ even if a higher-priority source arrives.
  - ACTIVE: inHandler=1; trapReq=0; no new request (no nesting). mretIn goes to IDLE.
- Strobe and pulse qualification:
  - mcauseWe and mepcWe are never asserted outside REQ.
  - trapTaken in IDLE or ACTIVE is ignored.
  - mretIn outside ACTIVE is ignored.
- Latency: a rising edge on an enabled edge-mode source seen in cycle n sets PENDING at the end of n. trapReq is high in cycle n+2 (IDLE evaluates in n+1).
- A config write in the same cycle as the IDLE decision takes effect the next cycle (registers update at the edge).
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous), including dropping trapReq.

Decomposition:
- Shared constants in irq_pkg: register offsets (IRQ_ENABLE=0x0, IRQ_PENDING=0x4, IRQ_EDGE=0x8, IRQ_CTRL=0xC), the FSM state encoding, and the MCAUSE_INT_BIT position. These belong beside the existing global constants header.
- One natural sub-module: irq_prio_enc (combinational N_IRQ-bit lowest-index priority encoder, outputs valid + id).

Test Plan:
- Reset values: hold reset=0 with irqIn=8'hFF -> trapReq=0, inHandler=0, cfgRdata=0 at all four offsets.
- Basic edge trap: write EDGE=8'h08, ENABLE=8'h08, CTRL=1; pulse irqIn[3] at cycle n -> trapReq=1 at n+2, mcauseDi=32'h8000_0013. Pulse trapTaken -> mcauseWe=mepcWe=1 that cycle, PENDING[3]=0, inHandler=1. Pulse mretIn -> IDLE.
- Priority and no nesting: level-mode, ENABLE=8'h24, irqIn[5] and irqIn[2] high -> cause 0x8000_0012. After taking it, raise irqIn[0] (enabled) while in ACTIVE -> trapReq stays 0 until mretIn.
- GIE withdraw and precedence: in REQ, write CTRL=0 -> trapReq drops next cycle. Repeat with trapTaken in the same cycle as the write -> ACTIVE entered, strobes asserted.
- W1C: set edge PENDING[1], then write PENDING=8'h02 -> reads 0. Write and a new rise in the same cycle -> bit remains 1. W1C on a level-mode bit with irqIn high -> stays 1.
- Async reset mid-REQ: drop reset between clock edges while trapReq=1 -> trapReq=0 immediately, with no clk edge required.
